// File: rtl/kernel_coeff_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kernel_pkg
// Brief   : Shared constants, types and the 3x3 kernel table for the loader.
// Revision: 1.0 - initial release
// ============================================================================
package kernel_pkg;

  localparam int COEFF_W = 8;
  localparam int TAPS    = 9;
  localparam int SHIFT_W = 4;

  typedef logic signed [COEFF_W-1:0] coeff_t;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    IDLE   = 2'd1,
    FETCH  = 2'd2,
    STAGED = 2'd3
  } state_t;

  // Taps are listed row-major, tap 0 (top-left) first; taps past 8 read as 0.
  function automatic coeff_t kernel_coeff(input logic [2:0] k, input logic [3:0] t);
    coeff_t v [TAPS];
    case (k)
      3'd0:    v = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
      3'd1:    v = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
      3'd2:    v = '{8'sd1, 8'sd2, 8'sd1, 8'sd2, 8'sd4, 8'sd2, 8'sd1, 8'sd2, 8'sd1};
      3'd3:    v = '{8'sd0, -8'sd1, 8'sd0, -8'sd1, 8'sd5, -8'sd1, 8'sd0, -8'sd1, 8'sd0};
      3'd4:    v = '{-8'sd1, 8'sd0, 8'sd1, -8'sd2, 8'sd0, 8'sd2, -8'sd1, 8'sd0, 8'sd1};
      3'd5:    v = '{-8'sd1, -8'sd2, -8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd1, 8'sd2, 8'sd1};
      3'd6:    v = '{8'sd0, 8'sd1, 8'sd0, 8'sd1, -8'sd4, 8'sd1, 8'sd0, 8'sd1, 8'sd0};
      default: v = '{-8'sd2, -8'sd1, 8'sd0, -8'sd1, 8'sd1, 8'sd1, 8'sd0, 8'sd1, 8'sd2};
    endcase
    if (t < 4'd9) return v[t];
    return '0;
  endfunction

  function automatic logic [SHIFT_W-1:0] kernel_shift(input logic [2:0] k);
    case (k)
      3'd1:    return 4'd3;
      3'd2:    return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/kernel_coeff_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : kernel_coeff_loader_if
// Brief   : Select/frame inputs and active-kernel outputs of the loader.
// Revision: 1.0 - initial release
// ============================================================================
interface kernel_coeff_loader_if #(
  parameter int ADDR_W = 3
);
  import kernel_pkg::*;

  logic [ADDR_W-1:0]        i_kernel_addr;
  logic                     i_frame_start;
  logic [TAPS*COEFF_W-1:0]  o_coeffs;
  logic [SHIFT_W-1:0]       o_norm_shift;
  logic [ADDR_W-1:0]        o_active_addr;
  logic                     o_kernel_valid;
  logic                     o_kernel_changed;
  logic                     o_busy;

  modport master (
    output i_kernel_addr, i_frame_start,
    input  o_coeffs, o_norm_shift, o_active_addr, o_kernel_valid, o_kernel_changed, o_busy
  );

  modport slave (
    input  i_kernel_addr, i_frame_start,
    output o_coeffs, o_norm_shift, o_active_addr, o_kernel_valid, o_kernel_changed, o_busy
  );

endinterface
`default_nettype wire

// File: rtl/kernel_coeff_loader_rom.sv
`default_nettype none
// ============================================================================
// Module  : kernel_rom
// Brief   : Synchronous-read kernel coefficient ROM, one cycle of latency.
// Revision: 1.0 - initial release
// ============================================================================
module kernel_rom #(
  parameter int ADDR_W = 3
) (
  input  logic                  i_clk,
  input  logic [ADDR_W+3:0]     i_addr,
  output kernel_pkg::coeff_t    o_data
);
  import kernel_pkg::*;

  coeff_t r_data;

  always_ff @(posedge i_clk) begin
    r_data <= kernel_coeff(i_addr[ADDR_W+3:4], i_addr[3:0]);
  end

  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/kernel_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module  : kernel_coeff_loader
// Brief   : Fetches the selected kernel into a shadow bank, commits at vsync.
// Revision: 1.0 - initial release
// ============================================================================
module kernel_coeff_loader #(
  parameter int ADDR_W = 3
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  kernel_coeff_loader_if.slave   bus
);
  import kernel_pkg::*;

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_fetch_addr;
  logic [3:0]               r_tap;
  logic                     r_booted;
  coeff_t                   r_shadow [TAPS];
  logic [SHIFT_W-1:0]       r_shadow_shift;

  logic [TAPS*COEFF_W-1:0]  r_coeffs;
  logic [SHIFT_W-1:0]       r_norm_shift;
  logic [ADDR_W-1:0]        r_active_addr;
  logic                     r_kernel_valid;
  logic                     r_kernel_changed;
  logic                     r_busy;

  logic                     w_addr_change;
  logic [ADDR_W+3:0]        w_rom_addr;
  coeff_t                   w_rom_data;

  assign w_addr_change = (bus.i_kernel_addr != r_fetch_addr);
  assign w_rom_addr    = {r_fetch_addr, r_tap};

  kernel_rom #(.ADDR_W(ADDR_W)) u_rom (
    .i_clk  (i_clk),
    .i_addr (w_rom_addr),
    .o_data (w_rom_data)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state          <= BOOT;
      r_fetch_addr     <= '0;
      r_tap            <= '0;
      r_booted         <= 1'b0;
      r_shadow_shift   <= '0;
      for (int i = 0; i < TAPS; i++) r_shadow[i] <= '0;
      r_coeffs         <= '0;
      r_norm_shift     <= '0;
      r_active_addr    <= '0;
      r_kernel_valid   <= 1'b0;
      r_kernel_changed <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_kernel_changed <= 1'b0;
      case (r_state)
        BOOT: begin
          r_fetch_addr <= bus.i_kernel_addr;
          r_tap        <= '0;
          r_state      <= FETCH;
          r_busy       <= 1'b1;
        end
        IDLE: begin
          if (w_addr_change) begin
            r_fetch_addr <= bus.i_kernel_addr;
            r_tap        <= '0;
            r_state      <= FETCH;
            r_busy       <= 1'b1;
          end
        end
        FETCH: begin
          // A new request restarts at tap 0; the partial shadow is simply overwritten.
          if (w_addr_change) begin
            r_fetch_addr <= bus.i_kernel_addr;
            r_tap        <= '0;
          end else begin
            if (r_tap == 4'd0) r_shadow_shift <= kernel_shift(r_fetch_addr);
            else               r_shadow[r_tap - 4'd1] <= w_rom_data;
            if (r_tap == 4'd9) r_state <= STAGED;
            else               r_tap   <= r_tap + 4'd1;
          end
        end
        STAGED: begin
          if (w_addr_change) begin
            r_fetch_addr <= bus.i_kernel_addr;
            r_tap        <= '0;
            r_state      <= FETCH;
          end else if (!r_booted || bus.i_frame_start) begin
            for (int i = 0; i < TAPS; i++) r_coeffs[i*COEFF_W +: COEFF_W] <= r_shadow[i];
            r_norm_shift     <= r_shadow_shift;
            r_active_addr    <= r_fetch_addr;
            r_kernel_valid   <= 1'b1;
            r_booted         <= 1'b1;
            r_kernel_changed <= 1'b1;
            r_busy           <= 1'b0;
            r_state          <= IDLE;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign bus.o_coeffs         = r_coeffs;
  assign bus.o_norm_shift     = r_norm_shift;
  assign bus.o_active_addr    = r_active_addr;
  assign bus.o_kernel_valid   = r_kernel_valid;
  assign bus.o_kernel_changed = r_kernel_changed;
  assign bus.o_busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_kernel_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_kernel_coeff_loader
// Brief   : Directed, table-driven self-checking bench for kernel_coeff_loader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_kernel_coeff_loader;

  typedef struct {
    logic [2:0]  addr;
    logic [71:0] coeffs;
    logic [3:0]  shift;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  kernel_coeff_loader_if #(.ADDR_W(3)) bus ();

  kernel_coeff_loader #(.ADDR_W(3)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected packed banks, written tap 8 (MSB) down to tap 0 (LSB).
  function automatic logic [71:0] exp_coeffs(input logic [2:0] k);
    case (k)
      3'd0:    return {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      3'd1:    return {8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
      3'd2:    return {8'h01, 8'h02, 8'h01, 8'h02, 8'h04, 8'h02, 8'h01, 8'h02, 8'h01};
      3'd3:    return {8'h00, 8'hFF, 8'h00, 8'hFF, 8'h05, 8'hFF, 8'h00, 8'hFF, 8'h00};
      3'd4:    return {8'h01, 8'h00, 8'hFF, 8'h02, 8'h00, 8'hFE, 8'h01, 8'h00, 8'hFF};
      3'd5:    return {8'h01, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFE, 8'hFF};
      3'd6:    return {8'h00, 8'h01, 8'h00, 8'h01, 8'hFC, 8'h01, 8'h00, 8'h01, 8'h00};
      default: return {8'h02, 8'h01, 8'h00, 8'h01, 8'h01, 8'hFF, 8'h00, 8'hFF, 8'hFE};
    endcase
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_changed(output int n);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (bus.o_kernel_changed) break;
    end
  endtask

  task automatic pulse_frame();
    bus.i_frame_start = 1'b1;
    tick();
    bus.i_frame_start = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] a, input logic [2:0] prev_a,
                         input logic [71:0] new_c, input logic [3:0] new_s);
    bus.i_kernel_addr = a;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("busy_fetch", 72'(bus.o_busy), 72'd1);
    end
    tick();
    tick();
    chk("staged_busy", 72'(bus.o_busy), 72'd1);
    chk("staged_no_change", 72'(bus.o_kernel_changed), 72'd0);
    chk("staged_hold_coeffs", bus.o_coeffs, exp_coeffs(prev_a));
    chk("staged_hold_addr", 72'(bus.o_active_addr), 72'(prev_a));
    pulse_frame();
    chk("commit_changed", 72'(bus.o_kernel_changed), 72'd1);
    chk("commit_coeffs", bus.o_coeffs, new_c);
    chk("commit_shift", 72'(bus.o_norm_shift), 72'(new_s));
    chk("commit_addr", 72'(bus.o_active_addr), 72'(a));
    chk("commit_valid", 72'(bus.o_kernel_valid), 72'd1);
    chk("commit_busy", 72'(bus.o_busy), 72'd0);
    tick();
    chk("changed_one_cycle", 72'(bus.o_kernel_changed), 72'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_coeffs"}, bus.o_coeffs, 72'd0);
    chk({name, "_shift"},  72'(bus.o_norm_shift), 72'd0);
    chk({name, "_addr"},   72'(bus.o_active_addr), 72'd0);
    chk({name, "_valid"},  72'(bus.o_kernel_valid), 72'd0);
    chk({name, "_chg"},    72'(bus.o_kernel_changed), 72'd0);
    chk({name, "_busy"},   72'(bus.o_busy), 72'd0);
  endtask

  vec_t tbl [8];

  initial begin
    int n;
    int pulses;
    logic [71:0] v;
    logic [2:0]  prev;

    for (int k = 0; k < 8; k++) begin
      tbl[k].addr   = 3'((k + 1) % 8);
      tbl[k].coeffs = exp_coeffs(3'((k + 1) % 8));
      tbl[k].shift  = ((k + 1) == 1) ? 4'd3 : ((k + 1) == 2) ? 4'd4 : 4'd0;
    end

    rst_n             = 1'b0;
    bus.i_kernel_addr = 3'd0;
    bus.i_frame_start = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");

    // Boot path: commit without any frame pulse.
    rst_n = 1'b1;
    wait_changed(n);
    chk("boot_latency", 72'(n), 72'd12);
    chk("boot_coeffs", bus.o_coeffs, exp_coeffs(3'd0));
    chk("boot_shift", 72'(bus.o_norm_shift), 72'd0);
    chk("boot_addr", 72'(bus.o_active_addr), 72'd0);
    chk("boot_valid", 72'(bus.o_kernel_valid), 72'd1);
    chk("boot_busy", 72'(bus.o_busy), 72'd0);
    tick();
    chk("boot_changed_pulse", 72'(bus.o_kernel_changed), 72'd0);

    // Walk 1..7 then wrap to 0, each committed at a frame start.
    prev = 3'd0;
    for (int k = 0; k < 8; k++) begin
      do_load(tbl[k].addr, prev, tbl[k].coeffs, tbl[k].shift);
      prev = tbl[k].addr;
    end

    // Abort: request 3, switch to 4 at FETCH cycle 5.
    bus.i_kernel_addr = 3'd3;
    tick();
    for (int i = 0; i < 5; i++) tick();
    bus.i_kernel_addr = 3'd4;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("abort_no_addr3", 72'(bus.o_active_addr), 72'd0);
    end
    pulse_frame();
    chk("abort_addr", 72'(bus.o_active_addr), 72'd4);
    chk("abort_coeffs", bus.o_coeffs, exp_coeffs(3'd4));
    v = bus.o_coeffs;
    chk("abort_tap0", 72'(v[7:0]), 72'hFF);
    chk("abort_tap2", 72'(v[23:16]), 72'h01);
    tick();

    // Frame pulse during FETCH is ignored and not remembered.
    bus.i_kernel_addr = 3'd6;
    tick();
    tick();
    tick();
    pulse_frame();
    chk("fetch_frame_no_commit", 72'(bus.o_kernel_changed), 72'd0);
    chk("fetch_frame_addr", 72'(bus.o_active_addr), 72'd4);
    for (int i = 0; i < 8; i++) tick();
    chk("fetch_frame_not_remembered", 72'(bus.o_active_addr), 72'd4);
    pulses = 0;
    pulse_frame();
    if (bus.o_kernel_changed) pulses++;
    chk("lap_coeffs", bus.o_coeffs, exp_coeffs(3'd6));
    chk("lap_addr", 72'(bus.o_active_addr), 72'd6);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.o_kernel_changed) pulses++;
    end
    chk("lap_one_pulse", 72'(pulses), 72'd1);

    // Frame start coincident with an address change in STAGED: change wins.
    bus.i_kernel_addr = 3'd7;
    for (int i = 0; i < 12; i++) tick();
    bus.i_kernel_addr = 3'd0;
    pulse_frame();
    chk("coinc_no_commit", 72'(bus.o_kernel_changed), 72'd0);
    chk("coinc_addr", 72'(bus.o_active_addr), 72'd6);
    chk("coinc_busy", 72'(bus.o_busy), 72'd1);
    for (int i = 0; i < 11; i++) tick();
    pulse_frame();
    chk("coinc_commit_addr", 72'(bus.o_active_addr), 72'd0);
    chk("coinc_commit_coeffs", bus.o_coeffs, exp_coeffs(3'd0));
    chk("coinc_commit_chg", 72'(bus.o_kernel_changed), 72'd1);
    tick();

    // Reset while STAGED, then boot commits the current address unprompted.
    bus.i_kernel_addr = 3'd2;
    for (int i = 0; i < 13; i++) tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    wait_changed(n);
    chk("reboot_latency", 72'(n), 72'd12);
    chk("reboot_coeffs", bus.o_coeffs, exp_coeffs(3'd2));
    chk("reboot_shift", 72'(bus.o_norm_shift), 72'd4);
    chk("reboot_addr", 72'(bus.o_active_addr), 72'd2);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
